// File: rtl/ex_cdb_arbiter_if.sv
// Packet type and the FU/complete-stage bundle for ex_cdb_arbiter.
// master = arbiter side; slave = functional units plus complete stage.
package ex_cdb_pkg;
    typedef struct packed {
        logic        valid;
        logic [5:0]  tag;
        logic [4:0]  dest;
        logic [31:0] result;
    } ex_packet_t;
endpackage

interface ex_cdb_if #(
    parameter int unsigned NUM_FU = 4,
    parameter int unsigned CNT_W  = $clog2(NUM_FU + 1)
);
    import ex_cdb_pkg::*;

    logic                           squash;
    ex_packet_t [NUM_FU-1:0]        fu_packet;
    logic       [NUM_FU-1:0]        fu_stall;
    ex_packet_t                     ex_reg;
    logic       [CNT_W-1:0]         pending_cnt;

    modport master (
        input  squash, fu_packet,
        output fu_stall, ex_reg, pending_cnt
    );

    modport slave (
        output squash, fu_packet,
        input  fu_stall, ex_reg, pending_cnt
    );
endinterface

// File: rtl/ex_cdb_arbiter.sv
// One-slot-per-FU result buffer with round-robin grant onto the registered ex_reg.
// Optional macro EX_ARB_BYPASS_EN lets an empty-slot FU win the same cycle it offers.
module ex_cdb_arbiter
    import ex_cdb_pkg::*;
#(
    parameter int unsigned NUM_FU = 4,
    parameter int unsigned CNT_W  = $clog2(NUM_FU + 1)
) (
    input  logic      clock,
    input  logic      reset,
    ex_cdb_if.master  cdb
);
    localparam int unsigned PTR_W = $clog2(NUM_FU);

    logic       [NUM_FU-1:0] r_slot_valid;
    ex_packet_t [NUM_FU-1:0] r_slot_pkt;
    logic       [PTR_W-1:0]  r_rr_ptr;
    ex_packet_t              r_ex_reg;
    logic       [CNT_W-1:0]  r_pending_cnt;

    logic       [NUM_FU-1:0] w_req;
    logic       [NUM_FU-1:0] w_grant;
    logic       [NUM_FU-1:0] w_stall;
    logic       [NUM_FU-1:0] w_load;
    logic       [NUM_FU-1:0] w_valid_d;
    logic                    w_any;
    logic       [PTR_W-1:0]  w_winner;
    logic       [PTR_W-1:0]  w_idx;
    logic       [PTR_W-1:0]  w_rr_next;
    ex_packet_t              w_win_pkt;
    logic       [CNT_W-1:0]  w_cnt_d;

    always_comb begin
        for (int unsigned i = 0; i < NUM_FU; i++) begin
`ifdef EX_ARB_BYPASS_EN
            w_req[i] = r_slot_valid[i] | cdb.fu_packet[i].valid;
`else
            w_req[i] = r_slot_valid[i];
`endif
        end
    end

    // Scan from the round-robin pointer; first requester wins.
    always_comb begin
        w_any    = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        w_grant  = '0;
        for (int unsigned off = 0; off < NUM_FU; off++) begin
            w_idx = PTR_W'((32'(r_rr_ptr) + off) % NUM_FU);
            if (!w_any && w_req[w_idx]) begin
                w_any    = 1'b1;
                w_winner = w_idx;
            end
        end
        if (w_any) begin
            w_grant[w_winner] = 1'b1;
        end
    end

    always_comb begin
        w_win_pkt = r_slot_pkt[w_winner];
`ifdef EX_ARB_BYPASS_EN
        if (!r_slot_valid[w_winner]) begin
            w_win_pkt = cdb.fu_packet[w_winner];
        end
`endif
        w_win_pkt.valid = 1'b1;
        w_rr_next = (32'(w_winner) == NUM_FU - 1) ? '0 : w_winner + 1'b1;
    end

    // A slot being drained this cycle may refill in the same cycle.
    always_comb begin
        w_cnt_d = '0;
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            w_stall[i] = !cdb.squash && r_slot_valid[i] && !w_grant[i];
            w_load[i]  = cdb.fu_packet[i].valid && !w_stall[i] && !cdb.squash;
`ifdef EX_ARB_BYPASS_EN
            if (w_grant[i] && !r_slot_valid[i]) begin
                w_load[i] = 1'b0;
            end
`endif
            if (cdb.squash) begin
                w_valid_d[i] = 1'b0;
            end else if (w_load[i]) begin
                w_valid_d[i] = 1'b1;
            end else if (w_grant[i]) begin
                w_valid_d[i] = 1'b0;
            end else begin
                w_valid_d[i] = r_slot_valid[i];
            end
            w_cnt_d = w_cnt_d + CNT_W'(w_valid_d[i]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_slot_valid  <= '0;
            r_slot_pkt    <= '0;
            r_rr_ptr      <= '0;
            r_ex_reg      <= '0;
            r_pending_cnt <= '0;
        end else begin
            r_slot_valid  <= w_valid_d;
            r_pending_cnt <= w_cnt_d;
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                if (w_load[i]) begin
                    r_slot_pkt[i] <= cdb.fu_packet[i];
                end
            end
            // Squash discards the grant and leaves the pointer where it was.
            if (cdb.squash) begin
                r_ex_reg <= '0;
            end else if (w_any) begin
                r_ex_reg <= w_win_pkt;
                r_rr_ptr <= w_rr_next;
            end else begin
                r_ex_reg <= '0;
            end
        end
    end

    assign cdb.fu_stall    = w_stall;
    assign cdb.ex_reg      = r_ex_reg;
    assign cdb.pending_cnt = r_pending_cnt;
endmodule
